// File: rtl/waveform_loader.sv
// Waveform BRAM loader: accepts samples from a valid/ready stream and writes them
// sequentially into BRAM port A, then raises play_en for the playback reader.
// Optional tail padding with the last sample is compiled in by WAVEFORM_LOADER_PAD_EN.
module waveform_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_abort,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_we,
    output logic [DATA_WIDTH-1:0] bram_data_o,
    output logic                  busy,
    output logic                  done,
    output logic                  play_en
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
`ifdef WAVEFORM_LOADER_PAD_EN
    localparam logic [1:0] StPad  = 2'd2;
`endif
    localparam logic [1:0] StDone = 2'd3;

    // Full BRAM depth, one bit wider than the address so it is representable.
    localparam logic [ADDR_WIDTH:0] Depth = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] One   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic                  start_q;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  play_q, play_d;

    logic                  start;
    logic                  handshake;
    logic [ADDR_WIDTH:0]   len_eff;

    assign start     = load_start & ~start_q;
    assign len_eff   = ((load_len == '0) || (load_len > Depth)) ? Depth : load_len;
    // Ready drops as soon as the last sample has been accepted.
    assign s_tready  = (state_q == StLoad) && (count_q < len_q);
    assign handshake = s_tvalid & s_tready;
    assign busy      = (state_q == StLoad)
`ifdef WAVEFORM_LOADER_PAD_EN
                     | (state_q == StPad)
`endif
                     ;

    assign bram_addr   = addr_q;
    assign bram_we     = we_q;
    assign bram_data_o = data_q;
    assign done        = done_q;
    assign play_en     = play_q;

    // Next-state: abort beats start, start restarts from any state.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        play_d  = play_q;

        if (load_abort) begin
            state_d = StIdle;
            play_d  = 1'b0;
        end else if (start) begin
            state_d = StLoad;
            len_d   = len_eff;
            count_d = '0;
            play_d  = 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (count_q == len_q) begin
                        // Last sample write is on the BRAM port this cycle.
`ifdef WAVEFORM_LOADER_PAD_EN
                        if (len_q != Depth) begin
                            state_d = StPad;
                        end else begin
                            state_d = StDone;
                            done_d  = 1'b1;
                            play_d  = 1'b1;
                        end
`else
                        state_d = StDone;
                        done_d  = 1'b1;
                        play_d  = 1'b1;
`endif
                    end else if (handshake) begin
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_WIDTH-1:0];
                        data_d  = s_tdata;
                        count_d = count_q + One;
                    end
                end
`ifdef WAVEFORM_LOADER_PAD_EN
                StPad: begin
                    // data_q still holds the last accepted sample.
                    if (count_q == Depth) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        play_d  = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_WIDTH-1:0];
                        count_d = count_q + One;
                    end
                end
`endif
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    // State and registered BRAM/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            len_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            play_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= load_start;
            len_q   <= len_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            play_q  <= play_d;
        end
    end

endmodule

// File: tb/tb_waveform_loader.sv
// Self-checking bench for waveform_loader (ADDR_WIDTH=4, DATA_WIDTH=32).
// Expected BRAM writes go into a scoreboard queue as samples are offered and are
// popped by a monitor whenever bram_we is seen. Honors WAVEFORM_LOADER_PAD_EN.
module tb_waveform_loader;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start, load_abort;
    logic [AW:0]   load_len;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tready;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic [DW-1:0] bram_data_o;
    logic          busy, done, play_en;

    waveform_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_abort (load_abort),
        .load_len   (load_len),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .bram_addr  (bram_addr),
        .bram_we    (bram_we),
        .bram_data_o(bram_data_o),
        .busy       (busy),
        .done       (done),
        .play_en    (play_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;     // required visible cycle, -1 = not checked
        bit            consec;  // must directly follow the previous write
    } wr_t;

    typedef struct {
        logic [AW:0]   len;
        logic [5:0]    pat;     // s_tvalid pattern, bit i used on offer cycle i%6
        logic [DW-1:0] base;
        bit            hold;    // keep load_start high through the load
    } vec_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  n_writes = 0;
    int  last_write_cyc = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every BRAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bram_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required=none (t=%0t)",
                         bram_addr, bram_data_o, $time);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("write_addr", 64'(bram_addr), 64'(e.addr));
                chk("write_data", 64'(bram_data_o), 64'(e.data));
                if (e.cyc >= 0) chk("write_latency", 64'(cyc), 64'(e.cyc));
                if (e.consec) chk("pad_consecutive", 64'(cyc), 64'(last_write_cyc + 1));
            end
            last_write_cyc = cyc;
            n_writes++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic int eff_of(input logic [AW:0] len);
        return (len == 0 || len > D) ? D : int'(len);
    endfunction

    // Rising edge on load_start; returns just after the edge that samples it.
    task automatic start_load(input logic [AW:0] len);
        @(posedge clk); #1;
        load_len   = len;
        load_start = 1'b1;
        s_tvalid   = 1'b0;
        @(posedge clk); #1;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_play_en_low", 64'(play_en), 64'd0);
    endtask

    // Offer samples per pattern until n are accepted; ends just after the last handshake edge.
    task automatic feed(input int n, input logic [5:0] pat, input logic [DW-1:0] base);
        int acc = 0;
        int i = 0;
        while (acc < n && i < 200) begin
            s_tvalid = pat[i % 6];
            s_tdata  = base + DW'(acc);
            @(negedge clk);
            chk("s_tready_load", 64'(s_tready), 64'd1);
            if (s_tvalid) begin
                sb.push_back('{addr: AW'(acc), data: base + DW'(acc), cyc: cyc + 1, consec: 1'b0});
                acc++;
            end
            @(posedge clk); #1;
            i++;
        end
        chk("feed_accepted", 64'(acc), 64'(n));
    endtask

    task automatic run_load(input vec_t v);
        int eff, d0, w0, exp_w;
        eff   = eff_of(v.len);
        d0    = done_cnt;
        w0    = n_writes;
        exp_w = eff;
        start_load(v.len);
        if (!v.hold) load_start = 1'b0;
        feed(eff, v.pat, v.base);
`ifdef WAVEFORM_LOADER_PAD_EN
        for (int a = eff; a < D; a++) begin
            sb.push_back('{addr: AW'(a), data: v.base + DW'(eff - 1), cyc: -1,
                           consec: (a != eff)});
        end
        exp_w = D;
`endif
        // An extra sample after the last one must be refused.
        s_tvalid = 1'b1;
        s_tdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("s_tready_drop", 64'(s_tready), 64'd0);
        s_tvalid = 1'b0;
        for (int k = 0; k < 60 && done_cnt == d0; k++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("done_after_last_write", 64'(done_cyc), 64'(last_write_cyc + 1));
        chk("play_en_high", 64'(play_en), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("done_s_tready", 64'(s_tready), 64'd0);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        chk("write_count", 64'(n_writes - w0), 64'(exp_w));
        if (v.hold) begin
            repeat (10) @(posedge clk);
            @(negedge clk); #1;
            chk("hold_no_restart_busy", 64'(busy), 64'd0);
            chk("hold_no_extra_done", 64'(done_cnt - d0), 64'd1);
            chk("hold_play_en", 64'(play_en), 64'd1);
            @(posedge clk); #1;
            load_start = 1'b0;
        end
    endtask

    vec_t vecs[6];

    initial begin
        int w0, d0;
        vecs[0] = '{len: 5'd16, pat: 6'b111111, base: 32'h0000_0100, hold: 1'b0};
        vecs[1] = '{len: 5'd4,  pat: 6'b101101, base: 32'h0000_0200, hold: 1'b0};
        vecs[2] = '{len: 5'd5,  pat: 6'b111111, base: 32'h0000_DEA9, hold: 1'b0};
        vecs[3] = '{len: 5'd0,  pat: 6'b111111, base: 32'h0000_0600, hold: 1'b0};
        vecs[4] = '{len: 5'd31, pat: 6'b110111, base: 32'h0000_0700, hold: 1'b1};
        vecs[5] = '{len: 5'd1,  pat: 6'b011111, base: 32'h0000_0800, hold: 1'b0};

        rst_n = 1'b0; load_start = 1'b0; load_abort = 1'b0; load_len = '0;
        s_tdata = '0; s_tvalid = 1'b0;
        #1;
        chk("reset_s_tready", 64'(s_tready), 64'd0);
        chk("reset_bram_we", 64'(bram_we), 64'd0);
        chk("reset_bram_addr", 64'(bram_addr), 64'd0);
        chk("reset_bram_data", 64'(bram_data_o), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_play_en", 64'(play_en), 64'd0);
        #21 rst_n = 1'b1;

        foreach (vecs[i]) run_load(vecs[i]);

        // Abort during LOAD with a sample handshaking in the same cycle.
        w0 = n_writes; d0 = done_cnt;
        start_load(5'd6);
        load_start = 1'b0;
        feed(2, 6'b111111, 32'h0000_0400);
        s_tvalid = 1'b1; s_tdata = 32'h0000_00AB; load_abort = 1'b1;
        @(posedge clk); #1;
        chk("abort_load_play_en", 64'(play_en), 64'd0);
        chk("abort_load_busy", 64'(busy), 64'd0);
        chk("abort_load_s_tready", 64'(s_tready), 64'd0);
        chk("abort_load_no_write", 64'(bram_we), 64'd0);
        load_abort = 1'b0;
        repeat (5) @(posedge clk);
        #1 s_tvalid = 1'b0;
        chk("abort_load_writes", 64'(n_writes - w0), 64'd2);
        chk("abort_load_no_done", 64'(done_cnt - d0), 64'd0);

`ifdef WAVEFORM_LOADER_PAD_EN
        // Abort after two PAD writes.
        w0 = n_writes; d0 = done_cnt;
        start_load(5'd2);
        load_start = 1'b0;
        feed(2, 6'b111111, 32'h0000_0500);
        sb.push_back('{addr: 4'd2, data: 32'h0000_0501, cyc: -1, consec: 1'b0});
        sb.push_back('{addr: 4'd3, data: 32'h0000_0501, cyc: -1, consec: 1'b1});
        repeat (3) @(posedge clk);
        #1 load_abort = 1'b1;
        @(posedge clk); #1;
        chk("abort_pad_play_en", 64'(play_en), 64'd0);
        chk("abort_pad_busy", 64'(busy), 64'd0);
        chk("abort_pad_no_write", 64'(bram_we), 64'd0);
        load_abort = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        chk("abort_pad_drained", 64'(sb.size()), 64'd0);
        chk("abort_pad_writes", 64'(n_writes - w0), 64'd4);
        chk("abort_pad_no_done", 64'(done_cnt - d0), 64'd0);
`endif

        // Asynchronous reset in the middle of a load.
        start_load(5'd8);
        load_start = 1'b0;
        feed(3, 6'b111111, 32'h0000_0300);
        s_tvalid = 1'b1;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        w0 = n_writes;
        chk("rst_mid_s_tready", 64'(s_tready), 64'd0);
        chk("rst_mid_bram_we", 64'(bram_we), 64'd0);
        chk("rst_mid_bram_addr", 64'(bram_addr), 64'd0);
        chk("rst_mid_bram_data", 64'(bram_data_o), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_play_en", 64'(play_en), 64'd0);
        chk("rst_mid_drained", 64'(sb.size()), 64'd0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk("post_rst_idle_ready", 64'(s_tready), 64'd0);
        chk("post_rst_idle_busy", 64'(busy), 64'd0);
        chk("post_rst_no_writes", 64'(n_writes - w0), 64'd0);
        s_tvalid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/waveform_loader.md
Name: waveform_loader

Overview:
- Upstream stage of the signal-generator BRAM playback reader.
- Accepts waveform samples from the PS-side stream (valid/ready) and writes them sequentially into the waveform BRAM port A.
- Optionally pads unused BRAM depth with the last sample.
- Raises a level play-enable whose rising edge starts playback in the reader.

Parameters:
- ADDR_WIDTH, 8, BRAM address width; depth D = 2^ADDR_WIDTH.
- DATA_WIDTH, 32, sample/BRAM word width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous assert, active-low.
- load_start  in  1  begin a load; acts on its rising edge only.
- load_abort  in  1  level; aborts any load and returns to IDLE.
- load_len  in  ADDR_WIDTH+1  number of samples to accept, latched on start.
- s_tdata  in  DATA_WIDTH  sample data.
- s_tvalid  in  1  sample valid.
- s_tready  out  1  loader ready for a sample.
- bram_addr  out  ADDR_WIDTH  BRAM write address.
- bram_we  out  1  BRAM write enable.
- bram_data_o  out  DATA_WIDTH  BRAM write data.
- busy  out  1  high in LOAD or PAD.
- done  out  1  one-cycle pulse when the load completes.
- play_en  out  1  level; high from completion until the next start or abort.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0: s_tready, bram_addr, bram_we, bram_data_o, busy, done, play_en. Internal start-edge register 0.
- Start detect: start = load_start & ~load_start_r, using the registered previous value.
- States: IDLE, LOAD, PAD, DONE.
- Length latch on start:
  - len_eff = D if load_len == 0 or load_len > D.
  - Otherwise len_eff = load_len.
- Start in any state, including LOAD, PAD and DONE: restarts the load.
  - word count = 0, next address = 0, play_en cleared the same edge, go to LOAD.
- load_abort is evaluated every cycle and has priority over start:
  - go to IDLE; play_en = 0, s_tready = 0, bram_we = 0.
  - An in-flight accepted sample is not written.
- LOAD:
  - s_tready = 1 (registered combinationally from state; no extra bubble).
  - Handshake = s_tvalid & s_tready.
  - Each handshake: cycle n+1 drives bram_we = 1, bram_addr = count, bram_data_o = s_tdata. Write latency is 1 cycle.
  - count increments and the last value is held.
  - When the handshake takes count to len_eff, s_tready drops on the next cycle.
  - Next state: PAD if len_eff < D and padding is compiled in; otherwise DONE.
- PAD:
  - s_tready = 0.
  - One write per cycle: addr = count … D-1, data = last accepted sample, bram_we = 1.
  - After the write to D-1, go to DONE.
- DONE:
  - done pulses for exactly 1 cycle on entry.
  - play_en = 1; stays 1 until the next start or abort.
  - s_tready = 0, bram_we = 0.
  - The state holds until start or abort.
- bram_we is 0 in every cycle not listed above.
- bram_addr/bram_data_o hold their last value when bram_we = 0.
- Address arithmetic is unsigned ADDR_WIDTH bits and never wraps: the last write address is always D-1 or len_eff-1.
- busy = (state == LOAD) | (state == PAD).
- s_tvalid while not in LOAD: ignored, no write, s_tready = 0.

Optional Feature:
- Macro: WAVEFORM_LOADER_PAD_EN.
- Defined: PAD state present. BRAM tail is filled with the last sample, so the reader, which plays until address D-1, sees a held level after the waveform.
- Undefined: no PAD state. LOAD goes straight to DONE after len_eff samples and addresses ≥ len_eff keep prior contents.
- Port list is identical in both builds.

Test Plan (ADDR_WIDTH=4, D=16, DATA_WIDTH=32):
- Reset mid-LOAD: assert rst_n=0 after 3 samples, asynchronously → all outputs 0 immediately; state IDLE; no further writes.
- Full load: load_len=16, continuous s_tvalid, data 0x100+i → 16 writes at addr 0..15, each 1 cycle after handshake; then done pulses once, play_en=1, no PAD writes.
- Backpressure and gaps: load_len=4, s_tvalid toggling 1,0,1,1,0,1 → exactly 4 writes at addr 0..3 with correct data; s_tready drops after the 4th handshake.
- Padding (PAD_EN defined): load_len=5, last sample 0xDEAD → writes addr 5..15 with 0xDEAD on 11 consecutive cycles, then done. Same stimulus undefined: no writes past addr 4, done 1 cycle after the last write.
- Length clamp: load_len=0 and load_len=31 → each accepts exactly 16 samples.
- Abort and restart:
  - abort during PAD → IDLE, play_en=0, no more writes.
  - Start while in DONE → play_en falls the same edge, load restarts at addr 0.
  - load_start held high → only one load begins.
